// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a WIDTH-bit word out MSB first, repeated reps times.
// Optional per-word even-parity bit when SERIAL_PATTERN_TX_PARITY_EN is defined.
module serial_pattern_tx #(
    parameter int WIDTH = 5,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [REP_W-1:0] reps,
    input  logic             abort,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [REP_W-1:0] ONE_REP = REP_W'(1);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             word_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            pat_q   <= '0;
            rep_q   <= '0;
            bit_q   <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            bit_q   <= bit_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Outputs are computed for the next cycle: bit_q indexes the bit on dout now.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        pat_d    = pat_q;
        rep_d    = rep_q;
        bit_d    = bit_q;
        dout_d   = 1'b0;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        word_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    pat_d   = pattern;
                    rep_d   = (reps == '0) ? ONE_REP : reps;
                    shreg_d = {pattern[WIDTH-2:0], 1'b0};
                    dout_d  = pattern[WIDTH-1];
                    valid_d = 1'b1;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    bit_d   = '0;
                end else if (bit_q == LAST_BIT) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    state_d = PAR;
                    dout_d  = ^pat_q;
                    valid_d = 1'b1;
                    bit_d   = '0;
`else
                    word_end = 1'b1;
`endif
                end else begin
                    dout_d  = shreg_q[WIDTH-1];
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    bit_d   = bit_q + 1'b1;
                    valid_d = 1'b1;
                end
            end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            PAR: begin
                if (abort) begin
                    state_d = IDLE;
                    bit_d   = '0;
                end else begin
                    word_end = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Either reload the word with no gap, or finish and pulse done.
        if (word_end) begin
            bit_d = '0;
            if (rep_q > ONE_REP) begin
                rep_d   = rep_q - ONE_REP;
                shreg_d = {pat_q[WIDTH-2:0], 1'b0};
                dout_d  = pat_q[WIDTH-1];
                valid_d = 1'b1;
                state_d = SHIFT;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    assign load_ready = (state_q == IDLE) && !reset;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

endmodule
